// File: rtl/scc_access_sched_if.sv
`default_nettype none
// ============================================================================
// Module : scc_access_sched_if
// Brief  : Request/response and SCC bus bundle for the SCC access scheduler.
// Rev    : 1.0  initial release
// ============================================================================
interface scc_access_sched_if;
  logic       req0_valid, req0_ready, req0_we, req0_ch, req0_dport;
  logic [3:0] req0_reg;
  logic [7:0] req0_wdata;
  logic       req1_valid, req1_ready, req1_we, req1_ch, req1_dport;
  logic [3:0] req1_reg;
  logic [7:0] req1_wdata;
  logic       resp0_done, resp1_done;
  logic [7:0] resp0_rdata, resp1_rdata;
  logic       scc_cs, scc_we;
  logic [1:0] scc_rs;
  logic [7:0] scc_wdata, scc_rdata;
  logic       busy;

  modport master (
    output req0_valid, req0_we, req0_ch, req0_dport, req0_reg, req0_wdata,
    output req1_valid, req1_we, req1_ch, req1_dport, req1_reg, req1_wdata,
    output scc_rdata,
    input  req0_ready, req1_ready, resp0_done, resp1_done, resp0_rdata, resp1_rdata,
    input  scc_cs, scc_we, scc_rs, scc_wdata, busy
  );

  modport slave (
    input  req0_valid, req0_we, req0_ch, req0_dport, req0_reg, req0_wdata,
    input  req1_valid, req1_we, req1_ch, req1_dport, req1_reg, req1_wdata,
    input  scc_rdata,
    output req0_ready, req1_ready, resp0_done, resp1_done, resp0_rdata, resp1_rdata,
    output scc_cs, scc_we, scc_rs, scc_wdata, busy
  );
endinterface
`default_nettype wire

// File: rtl/scc_access_sched.sv
`default_nettype none
// ============================================================================
// Module : scc_access_sched
// Brief  : Two-requester round-robin scheduler expanding logical SCC register
//          accesses into ph0-aligned Z8530 pointer/access strobe pairs.
// Rev    : 1.0  initial release
// ============================================================================
module scc_access_sched #(
  parameter int RECOVERY = 2
) (
  input logic               clk_14m,
  input logic               reset,
  input logic               ph0_en,
  scc_access_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PTR  = 2'd1,
    ACC  = 2'd2,
    CAPT = 2'd3
  } state_t;

  localparam logic [3:0] REC_LOAD = 4'(RECOVERY);

  state_t     state, state_nxt;
  logic       last_grant, cur;
  logic       l_we, l_ch, l_dport;
  logic [3:0] l_reg;
  logic [7:0] l_wdata;
  logic [3:0] rec_cnt;
  logic [7:0] rdata0_q, rdata1_q;

  logic       grant_any, grant_sel, sel_dport, accept, qualify, strobe;
  logic [3:0] sel_reg;
  logic       s_we;
  logic [1:0] s_rs;
  logic [7:0] s_wdata, cap;
  logic       done0, done1;

  always_comb begin
    grant_any = bus.req0_valid | bus.req1_valid;
    // Ties go to whichever requester was not granted last.
    grant_sel = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
    sel_dport = grant_sel ? bus.req1_dport : bus.req0_dport;
    sel_reg   = grant_sel ? bus.req1_reg   : bus.req0_reg;
    qualify   = ph0_en & (rec_cnt == 4'd0) & ~reset;
    cap       = l_we ? 8'h00 : bus.scc_rdata;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    strobe    = 1'b0;
    s_we      = 1'b0;
    s_rs      = 2'b00;
    s_wdata   = 8'h00;
    case (state)
      IDLE: begin
        if (grant_any && !reset) begin
          accept    = 1'b1;
          state_nxt = (!sel_dport && sel_reg != 4'd0) ? PTR : ACC;
        end
      end
      PTR: begin
        if (qualify) begin
          strobe    = 1'b1;
          s_we      = 1'b1;
          s_rs      = {1'b0, l_ch};
          s_wdata   = l_reg[3] ? {5'b00001, l_reg[2:0]} : {5'b00000, l_reg[2:0]};
          state_nxt = ACC;
        end
      end
      ACC: begin
        if (qualify) begin
          strobe    = 1'b1;
          s_we      = l_we;
          s_rs      = {l_dport, l_ch};
          s_wdata   = l_we ? l_wdata : 8'h00;
          state_nxt = CAPT;
        end
      end
      CAPT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign done0 = (state == CAPT) & ~reset & ~cur;
  assign done1 = (state == CAPT) & ~reset & cur;

  assign bus.req0_ready  = accept & ~grant_sel;
  assign bus.req1_ready  = accept & grant_sel;
  assign bus.resp0_done  = done0;
  assign bus.resp1_done  = done1;
  // Read data is presented combinationally with done and held afterwards.
  assign bus.resp0_rdata = done0 ? cap : rdata0_q;
  assign bus.resp1_rdata = done1 ? cap : rdata1_q;
  assign bus.scc_cs      = strobe;
  assign bus.scc_we      = s_we;
  assign bus.scc_rs      = s_rs;
  assign bus.scc_wdata   = s_wdata;
  assign bus.busy        = (state != IDLE);

  always_ff @(posedge clk_14m) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur        <= 1'b0;
      l_we       <= 1'b0;
      l_ch       <= 1'b0;
      l_dport    <= 1'b0;
      l_reg      <= 4'd0;
      l_wdata    <= 8'h00;
      rec_cnt    <= 4'd0;
      rdata0_q   <= 8'h00;
      rdata1_q   <= 8'h00;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= grant_sel;
        cur        <= grant_sel;
        l_we       <= grant_sel ? bus.req1_we    : bus.req0_we;
        l_ch       <= grant_sel ? bus.req1_ch    : bus.req0_ch;
        l_dport    <= sel_dport;
        l_reg      <= sel_reg;
        l_wdata    <= grant_sel ? bus.req1_wdata : bus.req0_wdata;
      end
      if (strobe) begin
        rec_cnt <= REC_LOAD;
      end else if (ph0_en && rec_cnt != 4'd0) begin
        rec_cnt <= rec_cnt - 4'd1;
      end
      if (done0) rdata0_q <= cap;
      if (done1) rdata1_q <= cap;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scc_access_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_scc_access_sched
// Brief  : Scoreboard bench for scc_access_sched (RECOVERY=2 and RECOVERY=0).
// Rev    : 1.0  initial release
// ============================================================================
module tb_scc_access_sched;

  typedef struct {
    logic       we;
    logic [1:0] rs;
    logic [7:0] wdata;
    int         gap;
  } strobe_t;

  logic clk, reset, ph0_en, sel;
  int   n_checks, n_errors, cyc, gap, last_strobe, rec_exp, ph_cnt;

  strobe_t    exp_strobe[$];
  bit         exp_grant[$];
  logic [7:0] exp_done0[$], exp_done1[$];

  scc_access_sched_if ifa ();
  scc_access_sched_if ifb ();

  scc_access_sched #(.RECOVERY(2)) dut_a (
    .clk_14m(clk), .reset(reset), .ph0_en(ph0_en), .bus(ifa)
  );
  scc_access_sched #(.RECOVERY(0)) dut_b (
    .clk_14m(clk), .reset(reset), .ph0_en(ph0_en), .bus(ifb)
  );

  assign ifb.req0_valid = ifa.req0_valid;
  assign ifb.req0_we    = ifa.req0_we;
  assign ifb.req0_ch    = ifa.req0_ch;
  assign ifb.req0_dport = ifa.req0_dport;
  assign ifb.req0_reg   = ifa.req0_reg;
  assign ifb.req0_wdata = ifa.req0_wdata;
  assign ifb.req1_valid = ifa.req1_valid;
  assign ifb.req1_we    = ifa.req1_we;
  assign ifb.req1_ch    = ifa.req1_ch;
  assign ifb.req1_dport = ifa.req1_dport;
  assign ifb.req1_reg   = ifa.req1_reg;
  assign ifb.req1_wdata = ifa.req1_wdata;
  assign ifb.scc_rdata  = ifa.scc_rdata;

  logic       m_cs, m_we, m_ready0, m_ready1, m_done0, m_done1, m_busy;
  logic [1:0] m_rs;
  logic [7:0] m_wdata, m_rdata0, m_rdata1;
  assign m_cs     = sel ? ifb.scc_cs      : ifa.scc_cs;
  assign m_we     = sel ? ifb.scc_we      : ifa.scc_we;
  assign m_rs     = sel ? ifb.scc_rs      : ifa.scc_rs;
  assign m_wdata  = sel ? ifb.scc_wdata   : ifa.scc_wdata;
  assign m_ready0 = sel ? ifb.req0_ready  : ifa.req0_ready;
  assign m_ready1 = sel ? ifb.req1_ready  : ifa.req1_ready;
  assign m_done0  = sel ? ifb.resp0_done  : ifa.resp0_done;
  assign m_done1  = sel ? ifb.resp1_done  : ifa.resp1_done;
  assign m_rdata0 = sel ? ifb.resp0_rdata : ifa.resp0_rdata;
  assign m_rdata1 = sel ? ifb.resp1_rdata : ifa.resp1_rdata;
  assign m_busy   = sel ? ifb.busy        : ifa.busy;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    ph0_en = 1'b0;
    ph_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      ph_cnt = (ph_cnt + 1) % 4;
      ph0_en = (ph_cnt == 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Monitor: pops scoreboard entries as the selected DUT produces events.
  always @(negedge clk) begin
    strobe_t s;
    bit g;
    logic [7:0] d;
    if (reset) begin
      gap = 99;
    end else begin
      if (m_ready0 || m_ready1) begin
        check_eq("ready_excl", {31'b0, m_ready0 & m_ready1}, 32'd0);
        if (exp_grant.size() == 0) check_eq("grant_unexp", 32'd1, 32'd0);
        else begin
          g = exp_grant.pop_front();
          check_eq("grant_port", {31'b0, m_ready1}, {31'b0, g});
        end
      end
      if (m_cs) begin
        check_eq("strobe_ph0", {31'b0, ph0_en}, 32'd1);
        if (exp_strobe.size() == 0) check_eq("strobe_unexp", 32'd1, 32'd0);
        else begin
          s = exp_strobe.pop_front();
          check_eq("strobe_we", {31'b0, m_we}, {31'b0, s.we});
          check_eq("strobe_rs", {30'b0, m_rs}, {30'b0, s.rs});
          check_eq("strobe_wdata", {24'b0, m_wdata}, {24'b0, s.wdata});
          if (s.gap >= 0) check_eq("strobe_gap", gap, s.gap);
          else if (gap < 99) check_eq("strobe_gap_min", {31'b0, gap >= rec_exp}, 32'd1);
        end
        gap = 0;
        last_strobe = cyc;
      end else begin
        check_eq("idle_bus", {21'b0, m_we, m_rs, m_wdata}, 32'd0);
        if (ph0_en && gap < 99) gap++;
      end
      if (m_done0) begin
        check_eq("done0_latency", cyc, last_strobe + 1);
        if (exp_done0.size() == 0) check_eq("done0_unexp", 32'd1, 32'd0);
        else begin
          d = exp_done0.pop_front();
          check_eq("done0_rdata", {24'b0, m_rdata0}, {24'b0, d});
        end
      end
      if (m_done1) begin
        check_eq("done1_latency", cyc, last_strobe + 1);
        if (exp_done1.size() == 0) check_eq("done1_unexp", 32'd1, 32'd0);
        else begin
          d = exp_done1.pop_front();
          check_eq("done1_rdata", {24'b0, m_rdata1}, {24'b0, d});
        end
      end
    end
    cyc++;
  end

  task automatic expect_txn(input bit port, input bit we, input bit ch, input bit dport,
                            input logic [3:0] rg, input logic [7:0] wd, input logic [7:0] rd,
                            input bit complete);
    strobe_t s;
    bit ptr;
    ptr = !dport && (rg != 4'd0);
    exp_grant.push_back(port);
    if (ptr) begin
      s.we = 1'b1; s.rs = {1'b0, ch}; s.wdata = {4'h0, rg}; s.gap = -1;
      exp_strobe.push_back(s);
    end
    if (complete) begin
      s.we = we; s.rs = {dport, ch}; s.wdata = we ? wd : 8'h00;
      s.gap = ptr ? rec_exp : -1;
      exp_strobe.push_back(s);
      if (port) exp_done1.push_back(we ? 8'h00 : rd);
      else      exp_done0.push_back(we ? 8'h00 : rd);
    end
  endtask

  task automatic issue(input bit port, input bit we, input bit ch, input bit dport,
                       input logic [3:0] rg, input logic [7:0] wd);
    bit got;
    got = 1'b0;
    @(posedge clk);
    #1;
    if (port) begin
      ifa.req1_we = we; ifa.req1_ch = ch; ifa.req1_dport = dport;
      ifa.req1_reg = rg; ifa.req1_wdata = wd; ifa.req1_valid = 1'b1;
    end else begin
      ifa.req0_we = we; ifa.req0_ch = ch; ifa.req0_dport = dport;
      ifa.req0_reg = rg; ifa.req0_wdata = wd; ifa.req0_valid = 1'b1;
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (port ? m_ready1 : m_ready0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check_eq("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (port) ifa.req1_valid = 1'b0;
    else      ifa.req0_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (exp_strobe.size() == 0 && exp_grant.size() == 0 && exp_done0.size() == 0 &&
          exp_done1.size() == 0 && !m_busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check_eq("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    bit seen;
    reset = 1'b1; sel = 1'b0; rec_exp = 2;
    n_checks = 0; n_errors = 0; cyc = 0; gap = 99; last_strobe = -10;
    ifa.req0_valid = 0; ifa.req0_we = 0; ifa.req0_ch = 0; ifa.req0_dport = 0;
    ifa.req0_reg = 0; ifa.req0_wdata = 0;
    ifa.req1_valid = 0; ifa.req1_we = 0; ifa.req1_ch = 0; ifa.req1_dport = 0;
    ifa.req1_reg = 0; ifa.req1_wdata = 0;
    ifa.scc_rdata = 8'h00;
    do_reset();
    @(negedge clk);
    check_eq("rst_ready", {30'b0, m_ready0, m_ready1}, 32'd0);
    check_eq("rst_done", {30'b0, m_done0, m_done1}, 32'd0);
    check_eq("rst_rdata", {16'b0, m_rdata0, m_rdata1}, 32'd0);
    check_eq("rst_scc", {20'b0, m_cs, m_we, m_rs, m_wdata}, 32'd0);
    check_eq("rst_busy", {31'b0, m_busy}, 32'd0);

    // WR9 write on channel A through the pointer
    expect_txn(0, 1, 1, 0, 4'd9, 8'hC0, 8'h00, 1);
    issue(0, 1, 1, 0, 4'd9, 8'hC0);
    wait_drain();

    // RR0 read on channel B: no pointer phase
    ifa.scc_rdata = 8'h44;
    expect_txn(1, 0, 0, 0, 4'd0, 8'h00, 8'h44, 1);
    issue(1, 0, 0, 0, 4'd0, 8'h00);
    wait_drain();

    // Data-port write ignores reg
    expect_txn(0, 1, 1, 1, 4'd7, 8'h55, 8'h00, 1);
    issue(0, 1, 1, 1, 4'd7, 8'h55);
    wait_drain();
    @(negedge clk);
    check_eq("rdata1_hold", {24'b0, m_rdata1}, 32'h44);
    check_eq("rdata0_write", {24'b0, m_rdata0}, 32'h00);

    // Simultaneous requests after reset: req0 wins first tie, then alternation
    do_reset();
    expect_txn(0, 1, 0, 0, 4'd1, 8'h11, 8'h00, 1);
    expect_txn(1, 0, 1, 1, 4'd0, 8'h00, 8'h44, 1);
    fork
      issue(0, 1, 0, 0, 4'd1, 8'h11);
      issue(1, 0, 1, 1, 4'd0, 8'h00);
    join
    wait_drain();
    expect_txn(0, 1, 1, 1, 4'd0, 8'hA5, 8'h00, 1);
    expect_txn(1, 1, 0, 1, 4'd0, 8'h5A, 8'h00, 1);
    fork
      issue(0, 1, 1, 1, 4'd0, 8'hA5);
      issue(1, 1, 0, 1, 4'd0, 8'h5A);
    join
    wait_drain();

    // Reset between pointer and access strobe of a WR12 write
    expect_txn(0, 1, 1, 0, 4'd12, 8'h33, 8'h00, 0);
    issue(0, 1, 1, 0, 4'd12, 8'h33);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_strobe.size() == 0) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("ptr_seen", {31'b0, seen}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", {31'b0, m_busy}, 32'd0);
    check_eq("abort_scc", {20'b0, m_cs, m_we, m_rs, m_wdata}, 32'd0);
    repeat (40) @(negedge clk);
    expect_txn(1, 1, 0, 1, 4'd0, 8'h77, 8'h00, 1);
    issue(1, 1, 0, 1, 4'd0, 8'h77);
    wait_drain();

    // RECOVERY=0 instance: RR3 read on channel A
    sel = 1'b1;
    rec_exp = 0;
    do_reset();
    ifa.scc_rdata = 8'h02;
    expect_txn(0, 0, 1, 0, 4'd3, 8'h00, 8'h02, 1);
    issue(0, 0, 1, 0, 4'd3, 8'h00);
    wait_drain();
    @(negedge clk);
    check_eq("b_rdata0_hold", {24'b0, m_rdata0}, 32'h02);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
